// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
package mem_arb_pkg;

  // Load/store size encoding; 2'b11 is treated as a word access.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // addr[17:16] value that selects the memory-mapped IO window.
  localparam logic [1:0] IO_REGION_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INS  = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  // Number of RAM byte cycles needed for a given access size.
  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction line-fill and the
// load/store buffer, sequencing each grant into per-byte RAM cycles.
//
// Handshake: ins_req/data_req are level-held by the requester until the
// matching one-cycle *_done pulse. A request still high in the done cycle is
// read as a fresh request, so requesters drop it in the done cycle unless
// they want a back-to-back transaction. Read data is valid only with done.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_REGION  = IO_REGION_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_pipline,
  input  logic                  ins_req,
  input  logic [ADDR_WIDTH-1:0] ins_addr,
  output logic [31:0]           ins_data,
  output logic                  ins_done,
  input  logic                  data_req,
  input  logic                  data_is_write,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic [31:0]           data_rdata,
  output logic                  data_done,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  output arb_state_e            dbg_state
);

  arb_state_e            state_q, state_d;
  arb_owner_e            last_grant_q, last_grant_d;
  arb_owner_e            owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            n_q, n_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            k_q, k_d;
  logic [31:0]           asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [31:0]           ins_data_q, ins_data_d;
  logic                  ins_done_q, ins_done_d;
  logic [31:0]           data_rdata_q, data_rdata_d;
  logic                  data_done_q, data_done_d;

  // The RAM keeps clocking during a pause, so the byte that arrives in the
  // first paused cycle is parked here and used on resume.
  logic                  was_rdy_q;
  logic [7:0]            din_hold_q;

  logic                  grant_data;
  logic                  io_blocked;
  logic [7:0]            din_eff;
  logic [1:0]            cap_idx;
  logic [2:0]            k_inc;

  // Arbitration, byte sequencing and next-output computation
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    n_d          = n_q;
    wdata_d      = wdata_q;
    k_d          = k_q;
    asm_d        = asm_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;
    ins_data_d   = ins_data_q;
    ins_done_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    data_done_d  = 1'b0;

    grant_data = data_req && (!ins_req || (last_grant_q == OWN_INS));
    io_blocked = (addr_q[17:16] == IO_REGION) && io_buffer_full;
    din_eff    = was_rdy_q ? mem_din : din_hold_q;
    cap_idx    = k_q[1:0] - 2'd1;
    k_inc      = k_q + 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (!flush_pipline && (ins_req || data_req)) begin
          k_d   = 3'd0;
          asm_d = '0;
          if (grant_data) begin
            owner_d      = OWN_DATA;
            last_grant_d = OWN_DATA;
            addr_d       = data_addr;
            n_d          = size_to_count(data_size);
            wdata_d      = data_wdata;
            if (data_is_write) begin
              state_d = ST_WRITE;
              if (!((data_addr[17:16] == IO_REGION) && io_buffer_full)) begin
                mem_wr_d   = 1'b1;
                mem_a_d    = data_addr;
                mem_dout_d = data_wdata[7:0];
              end
            end else begin
              state_d = ST_READ;
              mem_a_d = data_addr;
            end
          end else begin
            owner_d      = OWN_INS;
            last_grant_d = OWN_INS;
            addr_d       = ins_addr;
            n_d          = 3'd4;
            state_d      = ST_READ;
            mem_a_d      = ins_addr;
          end
        end
      end

      // k counts addresses already presented; byte k-1 arrives this cycle.
      ST_READ: begin
        if (flush_pipline) begin
          state_d = ST_IDLE;
        end else begin
          if (k_q != 3'd0) begin
            asm_d[{cap_idx, 3'b000} +: 8] = din_eff;
          end
          if (k_q == n_q) begin
            state_d = ST_IDLE;
            if (owner_q == OWN_INS) begin
              ins_done_d = 1'b1;
              ins_data_d = asm_d;
            end else begin
              data_done_d  = 1'b1;
              data_rdata_d = asm_d;
            end
          end else begin
            k_d = k_inc;
            if (k_inc < n_q) begin
              mem_a_d = addr_q + ADDR_WIDTH'(k_inc);
            end
          end
        end
      end

      // k is the byte being written (mem_wr_q high) or waiting on IO space.
      ST_WRITE: begin
        if (mem_wr_q) begin
          if (k_q == n_q - 3'd1) begin
            state_d     = ST_IDLE;
            data_done_d = 1'b1;
          end else begin
            k_d = k_inc;
            if (!io_blocked) begin
              mem_wr_d   = 1'b1;
              mem_a_d    = addr_q + ADDR_WIDTH'(k_inc);
              mem_dout_d = wdata_q[{k_inc[1:0], 3'b000} +: 8];
            end
          end
        end else if (!io_blocked) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = addr_q + ADDR_WIDTH'(k_q);
          mem_dout_d = wdata_q[{k_q[1:0], 3'b000} +: 8];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; everything holds while rdy_in is low
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_INS;
      owner_q      <= OWN_INS;
      addr_q       <= '0;
      n_q          <= 3'd0;
      wdata_q      <= '0;
      k_q          <= 3'd0;
      asm_q        <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      ins_data_q   <= '0;
      ins_done_q   <= 1'b0;
      data_rdata_q <= '0;
      data_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      n_q          <= n_d;
      wdata_q      <= wdata_d;
      k_q          <= k_d;
      asm_q        <= asm_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      ins_data_q   <= ins_data_d;
      ins_done_q   <= ins_done_d;
      data_rdata_q <= data_rdata_d;
      data_done_q  <= data_done_d;
    end
  end

  // Track pauses and park the first read byte that lands during one
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      was_rdy_q  <= 1'b0;
      din_hold_q <= '0;
    end else begin
      was_rdy_q <= rdy_in;
      if (was_rdy_q) begin
        din_hold_q <= mem_din;
      end
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q & rdy_in;
  assign ins_data   = ins_data_q;
  assign ins_done   = ins_done_q;
  assign data_rdata = data_rdata_q;
  assign data_done  = data_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: vector table of single transactions plus
// hand-written multi-cycle sequences (contention, flush, IO stall, pause, reset).
module tb_memory_arbiter;
  import mem_arb_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_pipline;
  logic        ins_req, data_req, data_is_write, io_buffer_full;
  logic [31:0] ins_addr, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic [31:0] ins_data, data_rdata, mem_a;
  logic        ins_done, data_done, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  arb_state_e  dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];

  memory_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_data(ins_data), .ins_done(ins_done),
    .data_req(data_req), .data_is_write(data_is_write), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_done(data_done), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  // Synchronous RAM model: read byte appears one cycle after its address
  logic [7:0] ram [bit [31:0]];
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  typedef struct {
    logic        is_ins;
    logic        is_wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    ins_req = 1'b0; data_req = 1'b0; data_is_write = 1'b0; data_size = 2'b00;
    ins_addr = '0; data_addr = '0; data_wdata = '0;
    flush_pipline = 1'b0; io_buffer_full = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  // Issue one request in the current cycle (cycle 0) and wait for its done.
  task automatic run_txn(input logic is_ins, input logic is_wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got, output int lat);
    got = '0;
    lat = -1;
    if (is_ins) begin
      ins_req = 1'b1; ins_addr = addr;
    end else begin
      data_req = 1'b1; data_is_write = is_wr; data_size = size;
      data_addr = addr; data_wdata = wdata;
    end
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (is_ins ? ins_done : data_done) begin
        lat = c;
        got = is_ins ? ins_data : data_rdata;
        break;
      end
    end
    ins_req = 1'b0;
    data_req = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    int          lat;
    int          idx;
    int          wr_cnt;
    int          done_c;
    int          first_wr;
    logic        seen;
    logic [31:0] wr_addr;
    logic [7:0]  wr_byte;

    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;

    //             ins   wr    size   addr        wdata          exp_data      lat
    vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h100,  32'h0,         32'h00100513, 6};
    vecs[1]  = '{1'b0, 1'b1, 2'b01, 32'h2000, 32'h0000BEEF,  32'h0,        3};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h2001, 32'h0,         32'h000000BE, 3};
    vecs[3]  = '{1'b0, 1'b0, 2'b01, 32'h2000, 32'h0,         32'h0000BEEF, 4};
    vecs[4]  = '{1'b0, 1'b1, 2'b10, 32'h3000, 32'hDEADBEEF,  32'h0,        5};
    vecs[5]  = '{1'b0, 1'b0, 2'b10, 32'h3000, 32'h0,         32'hDEADBEEF, 6};
    vecs[6]  = '{1'b0, 1'b0, 2'b11, 32'h3000, 32'h0,         32'hDEADBEEF, 6};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 32'h3002, 32'h12345677,  32'h0,        2};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h3000, 32'h0,         32'hDE77BEEF, 6};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'h200,  32'h0,         32'h44332211, 6};
    vecs[10] = '{1'b0, 1'b0, 2'b01, 32'h201,  32'h0,         32'h00003322, 4};
    vecs[11] = '{1'b0, 1'b1, 2'b01, 32'h3004, 32'hFFFFA55A,  32'h0,        3};
    vecs[12] = '{1'b0, 1'b0, 2'b10, 32'h3004, 32'h0,         32'h0000A55A, 6};

    drive_idle();
    rst_in = 1'b1;
    tick();
    tick();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_dones", {30'h0, ins_done, data_done}, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_in = 1'b0;
    tick();

    // Instruction fetch address trace
    ins_req = 1'b1; ins_addr = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) check($sformatf("fetch_mem_a_c%0d", c), mem_a, 32'h100 + 32'(c - 1));
      if (c == 5) check("fetch_no_early_done", 32'(ins_done), 32'h0);
      if (c == 6) begin
        check("fetch_done_c6", 32'(ins_done), 32'h1);
        check("fetch_data", ins_data, 32'h00100513);
        ins_req = 1'b0;
      end
    end
    tick();

    // Store half write trace
    data_req = 1'b1; data_is_write = 1'b1; data_size = 2'b01;
    data_addr = 32'h2000; data_wdata = 32'h0000BEEF;
    tick();
    check("sth_c1", {mem_wr, 15'h0, mem_a[7:0], mem_dout}, {1'b1, 15'h0, 8'h00, 8'hEF});
    tick();
    check("sth_c2", {mem_wr, 15'h0, mem_a[7:0], mem_dout}, {1'b1, 15'h0, 8'h01, 8'hBE});
    tick();
    check("sth_c3", {30'h0, mem_wr, data_done}, 32'h1);
    data_req = 1'b0;
    tick();

    // Vector table
    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i].is_ins, vecs[i].is_wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, got, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].is_wr) check($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
      tick();
      check($sformatf("vec%0d_pulse_width", i), {30'h0, ins_done, data_done}, 32'h0);
    end

    // Contention from reset: DATA, INS, DATA, INS back to back
    apply_reset();
    exp_q.push_back({1'b1, 32'h44332211});
    exp_q.push_back({1'b0, 32'h00100513});
    exp_q.push_back({1'b1, 32'h44332211});
    exp_q.push_back({1'b0, 32'h00100513});
    ins_req = 1'b1; ins_addr = 32'h100;
    data_req = 1'b1; data_is_write = 1'b0; data_size = 2'b10; data_addr = 32'h200;
    idx = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ins_done || data_done) begin
        check($sformatf("contend%0d_owner_data", idx),
              {data_done, data_done ? data_rdata : ins_data}, exp_q.pop_front());
        check($sformatf("contend%0d_cycle", idx), 32'(c), 32'(6 * (idx + 1)));
        idx++;
        if (idx == 4) begin
          ins_req = 1'b0; data_req = 1'b0;
          break;
        end
      end
    end
    check("contend_count", 32'(idx), 32'd4);
    tick();

    // Flush aborts an instruction fetch
    ins_req = 1'b1; ins_addr = 32'h100;
    tick(); tick(); tick();
    check("flush_ins_busy", 32'(dbg_state), 32'(ST_READ));
    flush_pipline = 1'b1; ins_req = 1'b0;
    tick();
    flush_pipline = 1'b0;
    check("flush_ins_idle", 32'(dbg_state), 32'(ST_IDLE));
    seen = ins_done;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | ins_done;
    end
    check("flush_ins_no_done", 32'(seen), 32'h0);

    // Flush does not stop a word store
    data_req = 1'b1; data_is_write = 1'b1; data_size = 2'b10;
    data_addr = 32'h4000; data_wdata = 32'hCAFEF00D;
    wr_cnt = 0; done_c = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      flush_pipline = (c == 3);
      if (mem_wr) wr_cnt++;
      if (data_done) begin
        done_c = c; data_req = 1'b0;
        break;
      end
    end
    flush_pipline = 1'b0;
    check("flush_st_writes", 32'(wr_cnt), 32'd4);
    check("flush_st_done_cycle", 32'(done_c), 32'd5);
    tick();
    run_txn(1'b0, 1'b0, 2'b10, 32'h4000, 32'h0, got, lat);
    check("flush_st_readback", got, 32'hCAFEF00D);
    tick();

    // IO back-pressure on a byte store
    data_req = 1'b1; data_is_write = 1'b1; data_size = 2'b00;
    data_addr = 32'h30000; data_wdata = 32'h0000005A; io_buffer_full = 1'b1;
    wr_cnt = 0; done_c = -1; first_wr = -1; wr_addr = '0; wr_byte = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      io_buffer_full = (c < 3);
      if (mem_wr) begin
        wr_cnt++;
        if (first_wr < 0) begin
          first_wr = c; wr_addr = mem_a; wr_byte = mem_dout;
        end
      end
      if (data_done) begin
        done_c = c; data_req = 1'b0;
        break;
      end
    end
    io_buffer_full = 1'b0;
    check("io_first_write_cycle", 32'(first_wr), 32'd4);
    check("io_write_count", 32'(wr_cnt), 32'd1);
    check("io_write_beat", {wr_addr[23:0], wr_byte}, {24'h030000, 8'h5A});
    check("io_done_cycle", 32'(done_c), 32'd5);
    tick();

    // Pause for two cycles in the middle of a word load
    data_req = 1'b1; data_is_write = 1'b0; data_size = 2'b10; data_addr = 32'h200;
    seen = 1'b0; done_c = -1; got = '0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      rdy_in = !((c == 3) || (c == 4));
      seen = seen | mem_wr;
      if (c == 4 || c == 5) check($sformatf("pause_mem_a_c%0d", c), mem_a, 32'h202);
      if (data_done) begin
        done_c = c; got = data_rdata; data_req = 1'b0;
        break;
      end
    end
    rdy_in = 1'b1;
    check("pause_no_write", 32'(seen), 32'h0);
    check("pause_done_cycle", 32'(done_c), 32'd8);
    check("pause_data", got, 32'h44332211);
    tick();

    // Reset in the middle of a word store
    data_req = 1'b1; data_is_write = 1'b1; data_size = 2'b10;
    data_addr = 32'h5000; data_wdata = 32'h01020304;
    tick(); tick();
    check("rst_store_active", 32'(mem_wr), 32'h1);
    rst_in = 1'b1; data_req = 1'b0;
    tick();
    check("rst_mid_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mid_mem_a_dout", {mem_a[23:0], mem_dout}, 32'h0);
    check("rst_mid_dones", {30'h0, ins_done, data_done}, 32'h0);
    check("rst_mid_ins_data", ins_data, 32'h0);
    check("rst_mid_data_rdata", data_rdata, 32'h0);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
